// File: rtl/pin_vector_sequencer.sv
// Pin vector sequencer: pulls vectors from a source and paces them into the
// per-pin double-buffered register at the tester-cycle rate.
module pin_vector_sequencer #(
    parameter int CNT_W  = 8,
    parameter int VCNT_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [CNT_W-1:0]  CYCLE_LENGTH_1,
    input  logic [CNT_W-1:0]  CYCLE_LENGTH_2,
    input  logic              VEC_VALID,
    output logic              VEC_READY,
    input  logic              VEC_D,
    input  logic              VEC_FF,
    input  logic              VEC_TSET,
    input  logic              VEC_LAST,
    output logic              LOAD,
    output logic              TRANSFER,
    output logic              D,
    output logic              FF,
    output logic              TEST_CYCLE,
    output logic              EN_FF_LOGIC,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR_UNDERRUN,
    output logic [VCNT_W-1:0] VEC_COUNT
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_RUN,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               buf_full_q;
    logic               buf_tset_q;
    logic               buf_last_q;
    logic               last_seen_q;
    logic               active_tset_q;
    logic               active_last_q;
    logic               load_q;
    logic               xfer_q;
    logic               d_q;
    logic               ff_q;
    logic               test_cycle_q;
    logic               en_q;
    logic               done_q;
    logic               err_q;
    logic [VCNT_W-1:0]  vcount_q;

    logic [CNT_W-1:0]   len_sel;
    logic [CNT_W-1:0]   len;
    logic               running;
    logic               boundary;
    logic               accept;
    logic               start_xfer;

    // Lengths below 2 leave no load slot, so they run as 2.
    always_comb begin
        len_sel = active_tset_q ? CYCLE_LENGTH_2 : CYCLE_LENGTH_1;
        len     = (len_sel < CNT_W'(2)) ? CNT_W'(2) : len_sel;
    end

    assign running    = (state_q == S_PRIME) || (state_q == S_RUN);
    assign boundary   = (state_q == S_RUN) && (cnt_q >= len - CNT_W'(1));
    assign VEC_READY  = running && !buf_full_q && !boundary && !last_seen_q;
    assign accept     = VEC_VALID && VEC_READY;
    assign start_xfer = buf_full_q &&
                        (((state_q == S_PRIME)) ||
                         (boundary && !active_last_q));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            buf_full_q    <= 1'b0;
            buf_tset_q    <= 1'b0;
            buf_last_q    <= 1'b0;
            last_seen_q   <= 1'b0;
            active_tset_q <= 1'b0;
            active_last_q <= 1'b0;
            load_q        <= 1'b0;
            xfer_q        <= 1'b0;
            d_q           <= 1'b0;
            ff_q          <= 1'b0;
            test_cycle_q  <= 1'b0;
            en_q          <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            vcount_q      <= '0;
        end else begin
            load_q <= 1'b0;
            xfer_q <= 1'b0;

            if (accept) begin
                load_q      <= 1'b1;
                d_q         <= VEC_D;
                ff_q        <= VEC_FF;
                buf_tset_q  <= VEC_TSET;
                buf_last_q  <= VEC_LAST;
                last_seen_q <= VEC_LAST;
                buf_full_q  <= 1'b1;
            end

            // The pin register takes the buffer as the TRANSFER clock ends.
            if (xfer_q) begin
                test_cycle_q <= active_tset_q;
                vcount_q     <= vcount_q + VCNT_W'(1);
            end

            if (start_xfer) begin
                state_q       <= S_RUN;
                active_tset_q <= buf_tset_q;
                active_last_q <= buf_last_q;
                buf_full_q    <= 1'b0;
                xfer_q        <= 1'b1;
                en_q          <= 1'b1;
            end

            unique case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (START) begin
                        state_q       <= S_PRIME;
                        done_q        <= 1'b0;
                        err_q         <= 1'b0;
                        vcount_q      <= '0;
                        buf_full_q    <= 1'b0;
                        last_seen_q   <= 1'b0;
                        active_last_q <= 1'b0;
                    end
                end
                S_PRIME: begin
                    cnt_q <= '0;
                end
                S_RUN: begin
                    cnt_q <= start_xfer ? '0 : cnt_q + CNT_W'(1);
                    if (boundary && active_last_q) begin
                        state_q <= S_DONE;
                        en_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (boundary && !buf_full_q) begin
                        state_q <= S_ERROR;
                        en_q    <= 1'b0;
                        err_q   <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign LOAD         = load_q;
    assign TRANSFER     = xfer_q;
    assign D            = d_q;
    assign FF           = ff_q;
    assign TEST_CYCLE   = test_cycle_q;
    assign EN_FF_LOGIC  = en_q;
    assign BUSY         = running;
    assign DONE         = done_q;
    assign ERR_UNDERRUN = err_q;
    assign VEC_COUNT    = vcount_q;
endmodule

// File: tb/tb_pin_vector_sequencer.sv
// Bench for pin_vector_sequencer: directed vector runs with a transfer
// scoreboard filled at accept time and drained by a monitor.
module tb_pin_vector_sequencer;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [7:0]  CL1 = 8'd4;
    logic [7:0]  CL2 = 8'd4;
    logic        VEC_VALID = 1'b0;
    logic        VEC_D = 1'b0;
    logic        VEC_FF = 1'b0;
    logic        VEC_TSET = 1'b0;
    logic        VEC_LAST = 1'b0;
    logic        VEC_READY, LOAD, TRANSFER, D, FF, TEST_CYCLE;
    logic        EN_FF_LOGIC, BUSY, DONE, ERR_UNDERRUN;
    logic [15:0] VEC_COUNT;
    logic [25:0] outs;

    assign outs = {VEC_READY, LOAD, TRANSFER, D, FF, TEST_CYCLE,
                   EN_FF_LOGIC, BUSY, DONE, ERR_UNDERRUN, VEC_COUNT};

    pin_vector_sequencer #(.CNT_W(8), .VCNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .CYCLE_LENGTH_1(CL1), .CYCLE_LENGTH_2(CL2),
        .VEC_VALID(VEC_VALID), .VEC_READY(VEC_READY),
        .VEC_D(VEC_D), .VEC_FF(VEC_FF), .VEC_TSET(VEC_TSET),
        .VEC_LAST(VEC_LAST), .LOAD(LOAD), .TRANSFER(TRANSFER),
        .D(D), .FF(FF), .TEST_CYCLE(TEST_CYCLE),
        .EN_FF_LOGIC(EN_FF_LOGIC), .BUSY(BUSY), .DONE(DONE),
        .ERR_UNDERRUN(ERR_UNDERRUN), .VEC_COUNT(VEC_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic d;
        logic ff;
        logic tset;
        int   gap;
    } xfer_t;

    xfer_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    last_xfer_cyc = 0;
    int    done_cyc = 0;
    int    load_cnt = 0;
    int    xfer_cnt = 0;
    int    en_cnt = 0;
    int    prev_len = 0;
    bit    first_offer = 1'b1;
    bit    tc_pending = 1'b0;
    logic  tc_exp = 1'b0;
    logic  done_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic int eff(input logic [7:0] v);
        return (v < 8'd2) ? 2 : int'(v);
    endfunction

    task automatic monitor();
        xfer_t r;
        forever begin
            @(negedge CLK);
            cyc++;
            if (LOAD) load_cnt++;
            if (EN_FF_LOGIC) en_cnt++;
            if (DONE && !done_prev) done_cyc = cyc;
            done_prev = DONE;
            if (tc_pending) begin
                chk("test_cycle", 32'(TEST_CYCLE), 32'(tc_exp));
                tc_pending = 1'b0;
            end
            if (TRANSFER) begin
                xfer_cnt++;
                chk("load_xfer_overlap", 32'(LOAD), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_transfer: got 1 expected 0");
                end else begin
                    r = exp_q.pop_front();
                    chk("xfer_d", 32'(D), 32'(r.d));
                    chk("xfer_ff", 32'(FF), 32'(r.ff));
                    if (r.gap > 0)
                        chk("xfer_gap", cyc - last_xfer_cyc, r.gap);
                    tc_pending = 1'b1;
                    tc_exp = r.tset;
                end
                last_xfer_cyc = cyc;
            end
        end
    endtask

    task automatic start_run();
        VEC_VALID = 1'b0;
        VEC_LAST = 1'b0;
        first_offer = 1'b1;
        load_cnt = 0;
        xfer_cnt = 0;
        en_cnt = 0;
        @(posedge CLK);
        #1 START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    task automatic offer(input logic d, input logic ff, input logic tset,
                         input logic last);
        bit    got = 1'b0;
        xfer_t r;
        VEC_D = d;
        VEC_FF = ff;
        VEC_TSET = tset;
        VEC_LAST = last;
        VEC_VALID = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge CLK);
            got = VEC_READY;
        end
        if (!got) begin
            fail_now("offer_ready");
            return;
        end
        @(posedge CLK);
        r.d = d;
        r.ff = ff;
        r.tset = tset;
        r.gap = first_offer ? 0 : prev_len;
        prev_len = eff(tset ? CL2 : CL1);
        first_offer = 1'b0;
        exp_q.push_back(r);
        #1;
    endtask

    task automatic wait_done(input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge CLK);
            got = DONE;
        end
        if (!got) fail_now("wait_done");
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        fork
            monitor();
        join_none

        repeat (2) @(posedge CLK);
        #1 chk("reset_outputs", 32'(outs), 0);
        RST = 1'b1;

        // Three vectors at length 4
        CL1 = 8'd4;
        CL2 = 8'd4;
        start_run();
        offer(1'b1, 1'b0, 1'b0, 1'b0);
        offer(1'b0, 1'b1, 1'b0, 1'b0);
        offer(1'b1, 1'b0, 1'b0, 1'b1);
        VEC_LAST = 1'b0;
        wait_done(100);
        chk("t1_vec_count", 32'(VEC_COUNT), 3);
        chk("t1_transfers", xfer_cnt, 3);
        chk("t1_loads", load_cnt, 3);
        chk("t1_en_clocks", en_cnt, 12);
        chk("t1_done_delay", done_cyc - last_xfer_cyc, 4);
        repeat (3) @(negedge CLK);
        chk("t1_ready_after_done", 32'(VEC_READY), 0);
        chk("t1_no_extra_load", load_cnt, 3);
        chk("t1_queue_empty", exp_q.size(), 0);

        // Alternating timing sets, lengths 3 and 6
        CL1 = 8'd3;
        CL2 = 8'd6;
        start_run();
        offer(1'b1, 1'b1, 1'b0, 1'b0);
        offer(1'b0, 1'b0, 1'b1, 1'b0);
        offer(1'b1, 1'b0, 1'b0, 1'b0);
        offer(1'b0, 1'b1, 1'b1, 1'b1);
        wait_done(100);
        chk("t2_vec_count", 32'(VEC_COUNT), 4);
        chk("t2_test_cycle", 32'(TEST_CYCLE), 1);
        chk("t2_queue_empty", exp_q.size(), 0);

        // Lengths 0 and 1 both run as 2
        for (int k = 0; k < 2; k++) begin
            CL1 = (k == 0) ? 8'd0 : 8'd1;
            start_run();
            offer(1'b1, 1'b0, 1'b0, 1'b0);
            offer(1'b0, 1'b1, 1'b0, 1'b0);
            offer(1'b1, 1'b1, 1'b0, 1'b1);
            wait_done(100);
            chk("t3_transfers", xfer_cnt, 3);
            chk("t3_loads", load_cnt, 3);
            chk("t3_vec_count", 32'(VEC_COUNT), 3);
            chk("t3_queue_empty", exp_q.size(), 0);
        end

        // Source stalls after two vectors
        CL1 = 8'd4;
        start_run();
        offer(1'b1, 1'b0, 1'b0, 1'b0);
        offer(1'b0, 1'b1, 1'b0, 1'b0);
        VEC_VALID = 1'b0;
        repeat (10) @(negedge CLK);
        #1;
        chk("t4_underrun", 32'(ERR_UNDERRUN), 1);
        chk("t4_en_off", 32'(EN_FF_LOGIC), 0);
        chk("t4_busy_off", 32'(BUSY), 0);
        chk("t4_vec_count", 32'(VEC_COUNT), 2);
        VEC_VALID = 1'b1;
        repeat (5) @(negedge CLK);
        #1;
        chk("t4_ready_in_error", 32'(VEC_READY), 0);
        chk("t4_no_load_in_error", load_cnt, 2);
        chk("t4_queue_empty", exp_q.size(), 0);

        // Restart clears the error; single last vector at length 5
        CL1 = 8'd5;
        start_run();
        chk("t5_err_cleared", 32'(ERR_UNDERRUN), 0);
        chk("t5_busy", 32'(BUSY), 1);
        chk("t5_count_cleared", 32'(VEC_COUNT), 0);
        offer(1'b1, 1'b1, 1'b0, 1'b1);
        wait_done(100);
        chk("t5_loads", load_cnt, 1);
        chk("t5_transfers", xfer_cnt, 1);
        chk("t5_done_delay", done_cyc - last_xfer_cyc, 5);
        chk("t5_ready_low", 32'(VEC_READY), 0);

        // Reset in the middle of a run
        CL1 = 8'd4;
        start_run();
        offer(1'b1, 1'b0, 1'b0, 1'b0);
        offer(1'b0, 1'b1, 1'b0, 1'b0);
        VEC_VALID = 1'b0;
        @(posedge CLK);
        #2;
        chk("t6_running", 32'({BUSY, EN_FF_LOGIC}), 3);
        RST = 1'b0;
        #1 chk("t6_async_reset", 32'(outs), 0);
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        CL1 = 8'd3;
        start_run();
        offer(1'b1, 1'b1, 1'b0, 1'b0);
        offer(1'b0, 1'b0, 1'b0, 1'b1);
        wait_done(100);
        chk("t6_vec_count", 32'(VEC_COUNT), 2);
        chk("t6_transfers", xfer_cnt, 2);
        chk("t6_queue_empty", exp_q.size(), 0);

        repeat (2) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
